// File: rtl/esm_ready_select.sv
// Wakeup/select stage: tracks bs entries waiting on two source tags and round-robin selects a ready one.
// Latency: allocate-ready to output in 1 edge; wakeup to output in 2 edges (1 with ESM_WAKEUP_BYPASS_EN).
// Backpressure: the registered output holds while ready_valid & !issue_ready; no entry is freed during a stall.
module esm_ready_select #(
  parameter int bs    = 16,
  parameter int tag_w = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [$clog2(bs)-1:0] alloc_index,
  input  logic [tag_w-1:0]      alloc_tag0,
  input  logic [tag_w-1:0]      alloc_tag1,
  input  logic                  alloc_rdy0,
  input  logic                  alloc_rdy1,
  output logic                  alloc_err,
  input  logic                  wb_valid,
  input  logic [tag_w-1:0]      wb_tag,
  output logic                  ready_valid,
  output logic [$clog2(bs)-1:0] ready_index,
  input  logic                  issue_ready,
  output logic [$clog2(bs):0]   occupancy
);

  localparam int iw = $clog2(bs);
  localparam int ow = iw + 1;

  logic [bs-1:0]    ent_vld;
  logic [bs-1:0]    ent_rdy0;
  logic [bs-1:0]    ent_rdy1;
  logic [tag_w-1:0] ent_tag0 [bs];
  logic [tag_w-1:0] ent_tag1 [bs];

  logic [bs-1:0] wb_hit0;
  logic [bs-1:0] wb_hit1;
  logic [bs-1:0] elig;
  logic [iw-1:0] rr_ptr;
  logic [iw-1:0] scan_idx;
  logic [iw-1:0] cand_idx;
  logic          cand_vld;
  logic          load;
  logic          grant;
  logic          alloc_ok;
  logic          alloc_wake0;
  logic          alloc_wake1;

  always_comb begin
    wb_hit0 = '0;
    wb_hit1 = '0;
    for (int i = 0; i < bs; i++) begin
      wb_hit0[i] = wb_valid && ent_vld[i] && (ent_tag0[i] == wb_tag);
      wb_hit1[i] = wb_valid && ent_vld[i] && (ent_tag1[i] == wb_tag);
    end
  end

`ifdef ESM_WAKEUP_BYPASS_EN
  // Same-cycle broadcast counts toward eligibility, saving one cycle of wakeup latency.
  assign elig = ent_vld & (ent_rdy0 | wb_hit0) & (ent_rdy1 | wb_hit1);
`else
  assign elig = ent_vld & ent_rdy0 & ent_rdy1;
`endif

  // First eligible entry at or above rr_ptr, wrapping modulo bs.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < bs; i++) begin
      scan_idx = rr_ptr + iw'(i);
      if (!cand_vld && elig[scan_idx]) begin
        cand_vld = 1'b1;
        cand_idx = scan_idx;
      end
    end
  end

  assign load        = !ready_valid || issue_ready;
  assign grant       = load && cand_vld;
  assign alloc_ok    = alloc_valid && !ent_vld[alloc_index];
  assign alloc_wake0 = alloc_rdy0 || (wb_valid && (alloc_tag0 == wb_tag));
  assign alloc_wake1 = alloc_rdy1 || (wb_valid && (alloc_tag1 == wb_tag));

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld     <= '0;
      ent_rdy0    <= '0;
      ent_rdy1    <= '0;
      for (int i = 0; i < bs; i++) begin
        ent_tag0[i] <= '0;
        ent_tag1[i] <= '0;
      end
      rr_ptr      <= '0;
      ready_valid <= 1'b0;
      ready_index <= '0;
      alloc_err   <= 1'b0;
      occupancy   <= '0;
    end else begin
      ent_rdy0 <= ent_rdy0 | wb_hit0;
      ent_rdy1 <= ent_rdy1 | wb_hit1;
      // A granted entry is valid and an allocated one is not, so these never target the same index.
      if (grant) begin
        ent_vld[cand_idx] <= 1'b0;
      end
      if (alloc_ok) begin
        ent_vld[alloc_index]  <= 1'b1;
        ent_tag0[alloc_index] <= alloc_tag0;
        ent_tag1[alloc_index] <= alloc_tag1;
        ent_rdy0[alloc_index] <= alloc_wake0;
        ent_rdy1[alloc_index] <= alloc_wake1;
      end
      alloc_err <= alloc_valid && !alloc_ok;
      if (load) begin
        ready_valid <= cand_vld;
        if (cand_vld) begin
          ready_index <= cand_idx;
          rr_ptr      <= cand_idx + iw'(1);
        end
      end
      occupancy <= occupancy + ow'(alloc_ok) - ow'(grant);
    end
  end

endmodule

// File: tb/tb_esm_ready_select.sv
// Directed bench for esm_ready_select: scoreboard of expected grant indices plus point checks.
module tb_esm_ready_select;

  localparam int BS = 16;
  localparam int TW = 6;
  localparam int IW = $clog2(BS);

  logic          clk;
  logic          rst;
  logic          alloc_valid;
  logic [IW-1:0] alloc_index;
  logic [TW-1:0] alloc_tag0;
  logic [TW-1:0] alloc_tag1;
  logic          alloc_rdy0;
  logic          alloc_rdy1;
  logic          alloc_err;
  logic          wb_valid;
  logic [TW-1:0] wb_tag;
  logic          ready_valid;
  logic [IW-1:0] ready_index;
  logic          issue_ready;
  logic [IW:0]   occupancy;

  int passed;
  int total;
  int exp_q[$];

  esm_ready_select #(.bs(BS), .tag_w(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_index (alloc_index),
    .alloc_tag0  (alloc_tag0),
    .alloc_tag1  (alloc_tag1),
    .alloc_rdy0  (alloc_rdy0),
    .alloc_rdy1  (alloc_rdy1),
    .alloc_err   (alloc_err),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .ready_valid (ready_valid),
    .ready_index (ready_index),
    .issue_ready (issue_ready),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every output transfer must match the next expected index.
  always @(negedge clk) begin
    if (!rst && ready_valid && issue_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL xfer_unexpected got=%0d want=none", ready_index);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(ready_index) == e) passed++;
        else $display("FAIL xfer_idx got=%0d want=%0d", ready_index, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s got=%0d want=%0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int idx, input int t0, input int t1, input bit r0, input bit r1);
    alloc_valid = 1'b1;
    alloc_index = IW'(idx);
    alloc_tag0  = TW'(t0);
    alloc_tag1  = TW'(t1);
    alloc_rdy0  = r0;
    alloc_rdy1  = r1;
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_index = '0; alloc_tag0 = '0; alloc_tag1 = '0;
    alloc_rdy0 = 1'b0; alloc_rdy1 = 1'b0;
    wb_valid = 1'b0; wb_tag = '0; issue_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    chk("rst_idx", ready_index, 0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_rv", ready_valid, 0);
      chk("idle_occ", occupancy, 0);
      chk("idle_err", alloc_err, 0);
      tick();
    end

    // Single ready allocation goes straight through
    issue_ready = 1'b1;
    exp_q.push_back(5);
    do_alloc(5, 0, 0, 1, 1);
    chk("a5_occ1", occupancy, 1);
    chk("a5_rv0", ready_valid, 0);
    tick();
    chk("a5_rv", ready_valid, 1);
    chk("a5_idx", ready_index, 5);
    chk("a5_occ0", occupancy, 0);
    tick();
    chk("a5_drain", ready_valid, 0);

    // Wakeup of source 0 by tag 0x12
    exp_q.push_back(3);
    do_alloc(3, 'h12, 'h01, 0, 1);
    tick();
    wb_valid = 1'b1; wb_tag = TW'('h12);
    tick();
    wb_valid = 1'b0;
`ifdef ESM_WAKEUP_BYPASS_EN
    chk("wk_rv_c1", ready_valid, 1);
    chk("wk_idx", ready_index, 3);
`else
    chk("wk_rv_c1", ready_valid, 0);
    tick();
    chk("wk_rv_c2", ready_valid, 1);
    chk("wk_idx", ready_index, 3);
`endif
    tick(); tick();
    chk("wk_drain", ready_valid, 0);

    // Grants 0, 1, 15; then rr_ptr must have wrapped to 0 (0 beats 15)
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(15);
    exp_q.push_back(0); exp_q.push_back(15);
    do_alloc(0, 0, 0, 1, 1);
    do_alloc(1, 0, 0, 1, 1);
    do_alloc(15, 0, 0, 1, 1);
    tick();
    issue_ready = 1'b0;
    chk("rr_hold15", ready_index, 15);
    do_alloc(15, 0, 0, 1, 1);
    do_alloc(0, 0, 0, 1, 1);
    chk("rr_occ2", occupancy, 2);
    chk("rr_still15", ready_index, 15);
    issue_ready = 1'b1;
    tick();
    chk("rr_wrap0", ready_index, 0);
    tick();
    chk("rr_then15", ready_index, 15);
    tick();
    chk("rr_drain", ready_valid, 0);

    // Stall holds the output; no entry freed
    issue_ready = 1'b0;
    exp_q.push_back(2); exp_q.push_back(4);
    do_alloc(2, 0, 0, 1, 1);
    do_alloc(4, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_rv", ready_valid, 1);
      chk("stall_idx", ready_index, 2);
      chk("stall_occ", occupancy, 1);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    chk("stall_next", ready_index, 4);
    tick();
    chk("stall_drain", ready_valid, 0);

    // Fill all entries with unready sources, then a rejected allocation
    issue_ready = 1'b0;
    for (int i = 0; i < BS; i++) do_alloc(i, 'h20 + i, 'h20 + i, 0, 0);
    chk("full_occ", occupancy, 16);
    chk("full_err0", alloc_err, 0);
    do_alloc(7, 0, 0, 1, 1);
    chk("full_err1", alloc_err, 1);
    chk("full_occ_kept", occupancy, 16);
    tick();
    chk("full_err_pulse", alloc_err, 0);
    wb_valid = 1'b1; wb_tag = TW'('h29);
    tick();
    wb_valid = 1'b0;
    tick();
    chk("full_wk_rv", ready_valid, 1);
    chk("full_wk_idx", ready_index, 9);
    chk("full_wk_occ", occupancy, 15);

    // Reset mid-operation overrides a same-cycle alloc and wakeup
    rst = 1'b1;
    alloc_valid = 1'b1; alloc_index = '0;
    wb_valid = 1'b1; wb_tag = TW'('h20);
    tick();
    rst = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
    chk("mrst_rv", ready_valid, 0);
    chk("mrst_idx", ready_index, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_err", alloc_err, 0);

    // Allocation with a same-cycle matching broadcast is not lost
    issue_ready = 1'b1;
    exp_q.push_back(6);
    wb_valid = 1'b1; wb_tag = TW'('h33);
    do_alloc(6, 'h33, 0, 0, 1);
    wb_valid = 1'b0;
    chk("sw_occ", occupancy, 1);
    chk("sw_err", alloc_err, 0);
    tick();
    chk("sw_rv", ready_valid, 1);
    chk("sw_idx", ready_index, 6);
    tick();
    chk("sw_drain", ready_valid, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/esm_ready_select.md
Name: esm_ready_select

Overview:
- Wakeup/select stage directly upstream of the ESM core.
- Holds up to bs pending buffer entries, each waiting on two source tags.
- Snoops writeback tag broadcasts to mark sources ready.
- Each cycle, round-robin picks one fully-ready entry and presents its index on a registered valid/ready output that feeds the core's ready_index.

Parameters:
bs, 16, number of buffer entries; power of two, at least 2
tag_w, 6, width of producer (writeback) tags

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
alloc_valid  input  1  allocate request this cycle
alloc_index  input  $clog2(bs)  entry to allocate
alloc_tag0  input  tag_w  source-0 producer tag
alloc_tag1  input  tag_w  source-1 producer tag
alloc_rdy0  input  1  source 0 already ready at allocation
alloc_rdy1  input  1  source 1 already ready at allocation
alloc_err  output  1  registered pulse: allocation rejected
wb_valid  input  1  writeback broadcast valid
wb_tag  input  tag_w  writeback producer tag
ready_valid  output  1  ready_index holds a selected entry
ready_index  output  $clog2(bs)  selected entry index (to ESM core)
issue_ready  input  1  downstream accepts ready_index this cycle
occupancy  output  $clog2(bs)+1  count of pending entries (excludes output register)

Behaviour:
- Reset (synchronous, rst=1 at edge): all entry valid bits, ready bits and tags cleared; rr_ptr=0; ready_valid=0; ready_index=0; alloc_err=0; occupancy=0. Reset overrides any same-cycle alloc, wakeup or handshake.
- Entry state: valid, tag0, tag1, rdy0, rdy1. An entry is eligible when valid & rdy0 & rdy1.
- Allocation, alloc_valid=1:
  - If entry[alloc_index].valid=0 at the edge: write the entry with valid=1 and the given tags/ready bits.
  - Otherwise: the state is unchanged and alloc_err=1 for the next cycle. This includes an entry being moved to the output register in the same cycle.
  - alloc_err is 0 in every other cycle.
- Wakeup, wb_valid=1: every valid entry whose tag0 equals wb_tag gets rdy0 set; likewise tag1 sets rdy1.
  - Same-cycle allocation: if the allocated source tag equals wb_tag, the corresponding ready bit is written as 1 (no lost wakeup).
- Wakeup and selection (base build): wakeup bits become visible to selection the cycle after the broadcast.
- Selection (combinational from registered state):
  - Scan from rr_ptr upward, wrapping modulo bs.
  - The first eligible entry is the grant candidate.
- Output register load condition: load = (ready_valid==0) | issue_ready.
  - load=1 with a candidate present: ready_index <= candidate; ready_valid <= 1; the candidate's valid is cleared (entry freed); rr_ptr <= (candidate+1) mod bs.
  - load=1 with no candidate: ready_valid <= 0; ready_index holds its old value.
  - load=0 (stall): ready_valid and ready_index hold; no entry is freed; rr_ptr holds.
- Handshake:
  - A transfer occurs on any cycle with ready_valid & issue_ready.
  - ready_index is stable while ready_valid=1 and issue_ready=0.
  - Back-to-back transfers sustain one index per cycle.
- Latency (base):
  - Entry allocated with both sources ready at edge N: ready_valid at N+1, if the entry wins arbitration and the output register is free or draining.
  - Wakeup broadcast in cycle c: the entry can appear on the output at edge c+2.
- occupancy: registered count of valid entries. It is updated in the same edge as allocation (+1) and grant (−1); both together net to 0.
- Wrap-around: rr_ptr = bs−1 followed by a grant of entry bs−1 gives rr_ptr=0.
- Full: with all bs entries valid, every allocation is rejected with alloc_err.

Optional Feature:
- Macro: ESM_WAKEUP_BYPASS_EN.
- Defined: the eligibility check uses ready bits OR'd with the same-cycle wakeup match (valid entries only). A wakeup in cycle c can then appear on the output at edge c+1. Newly allocated entries are still not selectable in their allocation cycle.
- Undefined: base behaviour above, with one extra cycle of wakeup-to-select latency.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then inputs 0 → ready_valid=0, occupancy=0, alloc_err=0 held for 10 cycles.
- Allocate index 5 with rdy0=rdy1=1, issue_ready=1 → at the next edge ready_valid=1, ready_index=5, occupancy returns to 0, rr_ptr=6.
- Allocate index 3 with tag0=0x12, rdy0=0, rdy1=1; wb_tag=0x12 two cycles later → ready_index=3 two edges after the broadcast (base), one edge after it with ESM_WAKEUP_BYPASS_EN.
- Allocate entries 0, 1 and 15, all ready, with issue_ready=1 → grants in order 0, 1, 15; rr_ptr wraps to 0 after 15.
- Stall: entries 2 and 4 ready, issue_ready=0 for 4 cycles → ready_index=2 stable, occupancy=1. Then issue_ready=1 → next ready_index=4.
- Fill all 16 entries with rdy=0, then allocate index 7 → alloc_err=1 for exactly one cycle, occupancy=16. Assert rst mid-operation → all outputs return to reset values at the next edge.
